// File: rtl/stream_frame_mux.sv
// Frame-aware Avalon-ST multiplexer: forwards one of NUM_CH streams and switches only on packet boundaries.
// Optional frame counter enabled with `define STREAM_MUX_FRAME_COUNT_EN.
module stream_frame_mux #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DATA_W = 12,
    parameter int unsigned SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    input  logic [NUM_CH-1:0]        sop_in,
    input  logic [NUM_CH-1:0]        eop_in,
    input  logic [NUM_CH-1:0]        valid_in,
    output logic [NUM_CH-1:0]        ready_out,
    input  logic                     ready_in,
    output logic [DATA_W-1:0]        data_out,
    output logic                     sop_out,
    output logic                     eop_out,
    output logic                     valid_out,
    output logic [SEL_W-1:0]         active_ch,
    output logic                     switch_pending,
    output logic [15:0]              frame_count
);

    typedef enum logic {
        WAIT_SOP,
        IN_PKT
    } state_t;

    state_t             state;
    logic               a_valid;
    logic               a_sop;
    logic               a_eop;
    logic [DATA_W-1:0]  a_data;
    logic               a_ready;
    logic               a_acc;
    logic               a_load;
    logic               sel_ok;

    // Active-channel selection; idle channels are always drained to stay in lockstep.
    always_comb begin
        a_valid   = 1'b0;
        a_sop     = 1'b0;
        a_eop     = 1'b0;
        a_data    = '0;
        ready_out = '0;
        a_ready   = !valid_out || ready_in;
        for (int k = 0; k < int'(NUM_CH); k++) begin
            if (SEL_W'(k) == active_ch) begin
                a_valid = valid_in[k];
                a_sop   = sop_in[k];
                a_eop   = eop_in[k];
                a_data  = data_in[k*DATA_W +: DATA_W];
            end
            ready_out[k] = !reset && ((SEL_W'(k) == active_ch) ? a_ready : 1'b1);
        end
    end

    assign a_acc  = a_valid && a_ready;
    assign a_load = a_acc && ((state == IN_PKT) || a_sop);
    assign sel_ok = 32'(sel) < NUM_CH;

    // Output register, framing FSM and boundary-aligned channel switch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= WAIT_SOP;
            valid_out      <= 1'b0;
            sop_out        <= 1'b0;
            eop_out        <= 1'b0;
            data_out       <= '0;
            active_ch      <= '0;
            switch_pending <= 1'b0;
        end else begin
            if (a_load) begin
                valid_out <= 1'b1;
                sop_out   <= a_sop;
                eop_out   <= a_eop;
                data_out  <= a_data;
            end else if (ready_in) begin
                valid_out <= 1'b0;
            end

            case (state)
                WAIT_SOP: begin
                    if (a_acc && a_sop && !a_eop) begin
                        state          <= IN_PKT;
                        switch_pending <= sel_ok && (sel != active_ch);
                    end else begin
                        switch_pending <= 1'b0;
                        if (sel_ok) active_ch <= sel;
                    end
                end
                IN_PKT: begin
                    if (a_acc && a_eop) begin
                        state          <= WAIT_SOP;
                        switch_pending <= 1'b0;
                        if (sel_ok) active_ch <= sel;
                    end else begin
                        switch_pending <= sel_ok && (sel != active_ch);
                    end
                end
                default: state <= WAIT_SOP;
            endcase
        end
    end

`ifdef STREAM_MUX_FRAME_COUNT_EN
    logic [15:0] frame_cnt;

    // Counts frames as their eop beat leaves the output register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt <= '0;
        end else if (valid_out && ready_in && eop_out) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign frame_count = frame_cnt;
`else
    assign frame_count = '0;
`endif

endmodule
